// File: rtl/pc_pkg.sv
// Shared types and constants for the pc_gen program-counter block.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    TRAP,
    HALT
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JAL,
    SEL_JALR
  } next_sel_t;

  localparam int unsigned INSN_BYTES = 4;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_target_calc.sv
// Combinational next-PC candidates, priority select and misaligned-target flag.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IMM_SHIFT = 0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            br_taken,
  input  logic            jal,
  input  logic            jalr,
  output logic [XLEN-1:0] seq_pc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  next_sel_t       sel;
  logic [XLEN-1:0] imm_scaled;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_sum;

  assign seq_pc     = pc + XLEN'(INSN_BYTES);
  assign imm_scaled = imm << IMM_SHIFT;
  assign rel_target = pc + imm_scaled;
  assign jalr_sum   = rs1_val + imm;

  always_comb begin
    sel = SEL_SEQ;
    if (jalr)          sel = SEL_JALR;
    else if (jal)      sel = SEL_JAL;
    else if (br_taken) sel = SEL_BR;
  end

  always_comb begin
    target = seq_pc;
    case (sel)
      SEL_JALR:        target = {jalr_sum[XLEN-1:1], 1'b0};
      SEL_JAL, SEL_BR: target = rel_target;
      default:         target = seq_pc;
    endcase
  end

  // Sequential PCs stay aligned by construction; only redirects can fault.
  assign misaligned = (sel != SEL_SEQ) && is_misaligned(target[1:0]);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/halt FSM, fetch handshake, redirect select.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int unsigned     IMM_SHIFT = 0
) (
  input  logic            clk,
  input  logic            nclr,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  input  logic            br_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_addr,
  output logic            halted,
  output logic            trap,
  output logic [XLEN-1:0] epc
);

  pc_state_t       state, state_nxt;
  logic [XLEN-1:0] seq_pc, target;
  logic [XLEN-1:0] pc_nxt, epc_nxt;
  logic            misaligned, fire, trap_nxt;

  pc_target_calc #(
    .XLEN      (XLEN),
    .IMM_SHIFT (IMM_SHIFT)
  ) u_target (
    .pc         (pc),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .br_taken   (br_taken),
    .jal        (jal),
    .jalr       (jalr),
    .seq_pc     (seq_pc),
    .target     (target),
    .misaligned (misaligned)
  );

  assign fetch_valid = (state == RUN) && !stall;
  assign fire        = fetch_valid && fetch_ready;
  assign halted      = (state == HALT);
  assign link_addr   = seq_pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc;
    trap_nxt  = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      TRAP: begin
        pc_nxt    = TRAP_VEC;
        state_nxt = RUN;
      end
      HALT: if (resume) state_nxt = RUN;
      RUN: begin
        if (fire) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (misaligned) begin
            pc_nxt    = TRAP_VEC;
            epc_nxt   = pc;
            trap_nxt  = 1'b1;
            state_nxt = TRAP;
          end else begin
            pc_nxt = target;
            if (halt_req) state_nxt = HALT;
          end
`else
          // Without trapping, a faulting target is silently word-aligned.
          pc_nxt = misaligned ? {target[XLEN-1:2], 2'b00} : target;
          if (halt_req) state_nxt = HALT;
`endif
        end else if (halt_req) begin
          state_nxt = HALT;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state <= BOOT;
      pc    <= RESET_VEC;
      epc   <= '0;
      trap  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      epc   <= epc_nxt;
      trap  <= trap_nxt;
    end
  end

endmodule
